// File: rtl/race_handshake_if.sv
// Bundles the race request, start/finish handshake and debug outputs of race_handshake.
// The environment side uses master; the block itself uses slave.
interface race_handshake_if;
    logic       ready;
    logic       start;
    logic       done;
    logic       t;
    logic [1:0] official_state;
    logic [1:0] observer_state;
    logic [7:0] race_count;

    modport master (
        output ready,
        input  start, done, t, official_state, observer_state, race_count
    );

    modport slave (
        input  ready,
        output start, done, t, official_state, observer_state, race_count
    );
endinterface

// File: rtl/race_handshake.sv
// Start/finish race handshake: an official raises start, an observer times the race
// and answers with done, and an LFSR pulse generator paces the environment's requests.

module race_official (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic       done,
    output logic       start,
    output logic [1:0] state
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GO    = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic       start_r;
    logic       start_nxt_s;

    // State register; start is registered alongside so it is a clean Moore flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            start_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            start_r <= start_nxt_s;
        end
    end

    // Next-state logic; ready only matters in IDLE, code 3 falls back to IDLE
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (ready) begin
                    state_nxt_s = GO;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GO: begin
                if (done) begin
                    state_nxt_s = CLEAR;
                end else begin
                    state_nxt_s = GO;
                end
            end
            CLEAR: begin
                if (!done) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = CLEAR;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode from the state being entered
    always_comb begin
        start_nxt_s = (state_nxt_s == GO);
    end

    assign start = start_r;
    assign state = state_r;
endmodule

module race_observer #(
    parameter int RACE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       done,
    output logic [1:0] state,
    output logic [7:0] race_count
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] TIMING = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam logic [7:0] LAST   = 8'(RACE_CYCLES - 1);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;
    logic       finish_s;
    logic       done_r;
    logic       done_nxt_s;
    logic [7:0] race_count_r;
    logic [7:0] race_count_nxt_s;

    // State, cycle counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 8'd0;
            done_r       <= 1'b0;
            race_count_r <= 8'd0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            done_r       <= done_nxt_s;
            race_count_r <= race_count_nxt_s;
        end
    end

    // Next-state logic; a dropped start aborts timing before the finish test
    always_comb begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = cnt_r;
        finish_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = TIMING;
                    cnt_nxt_s   = 8'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            TIMING: begin
                if (!start) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == LAST) begin
                    state_nxt_s = DONE;
                    finish_s    = 1'b1;
                end else begin
                    state_nxt_s = TIMING;
                    cnt_nxt_s   = cnt_r + 8'd1;
                end
            end
            DONE: begin
                if (!start) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode; the race counter wraps naturally at 8 bits
    always_comb begin
        done_nxt_s = (state_nxt_s == DONE);
        if (finish_s) begin
            race_count_nxt_s = race_count_r + 8'd1;
        end else begin
            race_count_nxt_s = race_count_r;
        end
    end

    assign done       = done_r;
    assign state      = state_r;
    assign race_count = race_count_r;
endmodule

module random_timer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    output logic t
);
    logic [15:0] lfsr_r;

    function automatic logic lfsr_feedback(input logic [15:0] l);
        return l[15] ^ l[13] ^ l[12] ^ l[10];
    endfunction

    // Maximal-length Fibonacci LFSR; a nonzero seed keeps it out of the all-zero lockup
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_feedback(lfsr_r)};
        end
    end

    assign t = (lfsr_r[3:0] == 4'b0000);
endmodule

module race_handshake #(
    parameter int          RACE_CYCLES = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    race_handshake_if.slave  bus
);
    logic       start_s;
    logic       done_s;
    logic       t_s;
    logic [1:0] official_state_s;
    logic [1:0] observer_state_s;
    logic [7:0] race_count_s;

    // Each FSM sees only the other's registered flag, so there is no combinational loop
    race_official u_official (
        .clk   (clk),
        .rst   (rst),
        .ready (bus.ready),
        .done  (done_s),
        .start (start_s),
        .state (official_state_s)
    );

    race_observer #(.RACE_CYCLES(RACE_CYCLES)) u_observer (
        .clk        (clk),
        .rst        (rst),
        .start      (start_s),
        .done       (done_s),
        .state      (observer_state_s),
        .race_count (race_count_s)
    );

    random_timer #(.LFSR_SEED(LFSR_SEED)) u_timer (
        .clk (clk),
        .rst (rst),
        .t   (t_s)
    );

    assign bus.start          = start_s;
    assign bus.done           = done_s;
    assign bus.t              = t_s;
    assign bus.official_state = official_state_s;
    assign bus.observer_state = observer_state_s;
    assign bus.race_count     = race_count_s;
endmodule

// File: tb/tb_race_handshake.sv
// Directed bench for race_handshake: reset, LFSR sequence, race timing,
// ignored and back-to-back requests, paced protocol, count wrap and mid-race reset.
module tb_race_handshake;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    race_handshake_if bus ();

    race_handshake #(.RACE_CYCLES(4), .LFSR_SEED(16'hACE1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]  exp_cnt;
    logic [15:0] m;

    // Expected outputs sampled after edges N..N+8 of a race launched at edge N
    int st_e  [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    int dn_e  [9] = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
    int off_e [9] = '{1, 1, 1, 1, 1, 1, 2, 2, 0};
    int obs_e [9] = '{0, 1, 1, 1, 1, 2, 2, 0, 0};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // mode 0: ready pulsed; 1: ready held through GO/CLEAR then dropped; 2: ready held for a back-to-back race
    task automatic race(input int mode);
        logic [7:0] ec;
        for (int j = 0; j < 9; j++) begin
            ec = (j >= 5) ? exp_cnt + 8'd1 : exp_cnt;
            chk($sformatf("start j%0d", j), 32'(bus.start), 32'(st_e[j]));
            chk($sformatf("done j%0d", j), 32'(bus.done), 32'(dn_e[j]));
            chk($sformatf("official j%0d", j), 32'(bus.official_state), 32'(off_e[j]));
            chk($sformatf("observer j%0d", j), 32'(bus.observer_state), 32'(obs_e[j]));
            chk($sformatf("count j%0d", j), 32'(bus.race_count), 32'(ec));
            if (j < 8) begin
                bus.ready = (mode != 0);
                tick;
            end
        end
        exp_cnt = exp_cnt + 8'd1;
        bus.ready = (mode == 2);
        tick;
        if (mode != 2) begin
            chk("start j9", 32'(bus.start), 32'd0);
            chk("official j9", 32'(bus.official_state), 32'd0);
            chk("observer j9", 32'(bus.observer_state), 32'd0);
            chk("count j9", 32'(bus.race_count), 32'(exp_cnt));
        end
    endtask

    initial begin
        int bad_t;
        int zero_seen;
        int phase;
        int rises;
        bit order_ok;
        logic ps;
        logic pd;

        // Reset
        rst = 1'b1;
        bus.ready = 1'b0;
        tick;
        tick;
        chk("rst start", 32'(bus.start), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst official", 32'(bus.official_state), 32'd0);
        chk("rst observer", 32'(bus.observer_state), 32'd0);
        chk("rst count", 32'(bus.race_count), 32'd0);
        chk("rst t", 32'(bus.t), 32'd0);

        // LFSR: first 20 pulses against the reference, then a full period
        rst = 1'b0;
        m = 16'hACE1;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t step%0d", i), 32'(bus.t), 32'(m[3:0] == 4'd0));
            tick;
            m = lfsr_step(m);
        end
        bad_t = 0;
        zero_seen = 0;
        for (int i = 0; i < 65535; i++) begin
            if (bus.t !== (m[3:0] == 4'd0)) bad_t++;
            if (dut.u_timer.lfsr_r == 16'd0) zero_seen++;
            tick;
            m = lfsr_step(m);
        end
        chk("t long run", 32'(bad_t), 32'd0);
        chk("lfsr zero", 32'(zero_seen), 32'd0);

        // Single race, ignored requests, back-to-back races
        exp_cnt = 8'd0;
        bus.ready = 1'b1;
        tick;
        bus.ready = 1'b0;
        race(0);
        bus.ready = 1'b1;
        tick;
        race(1);
        bus.ready = 1'b1;
        tick;
        race(2);
        race(0);

        // Paced protocol: ready raised on t, dropped once start is seen
        phase = 0;
        rises = 0;
        order_ok = 1'b1;
        ps = bus.start;
        pd = bus.done;
        for (int c = 0; c < 260; c++) begin
            if (c < 200) begin
                if (bus.ready && bus.start) bus.ready = 1'b0;
                else if (!bus.ready && bus.t && !bus.start && !bus.done) bus.ready = 1'b1;
            end else begin
                bus.ready = 1'b0;
                if (phase == 0 && bus.official_state == 2'd0) break;
            end
            tick;
            if (!ps && bus.start) begin if (phase != 0) order_ok = 1'b0; phase = 1; end
            if (!pd && bus.done) begin if (phase != 1) order_ok = 1'b0; phase = 2; rises++; end
            if (ps && !bus.start) begin if (phase != 2) order_ok = 1'b0; phase = 3; end
            if (pd && !bus.done) begin if (phase != 3) order_ok = 1'b0; phase = 0; end
            ps = bus.start;
            pd = bus.done;
        end
        chk("paced order", 32'(order_ok), 32'd1);
        chk("paced settled", 32'(phase), 32'd0);
        chk("paced races seen", 32'(rises > 0), 32'd1);
        exp_cnt = exp_cnt + 8'(rises);
        chk("paced count", 32'(bus.race_count), 32'(exp_cnt));

        // Count wrap 255 -> 0 with ready held high
        bus.ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (bus.race_count == 8'd255) break;
            tick;
        end
        chk("count at 255", 32'(bus.race_count), 32'd255);
        for (int c = 0; c < 20; c++) begin
            tick;
            if (bus.race_count != 8'd255) break;
        end
        chk("count wrap", 32'(bus.race_count), 32'd0);
        bus.ready = 1'b0;
        for (int c = 0; c < 12; c++) tick;
        chk("idle after wrap", 32'(bus.official_state), 32'd0);

        // Mid-race reset at edge N+3
        bus.ready = 1'b1;
        tick;
        bus.ready = 1'b0;
        tick;
        tick;
        chk("mid-race timing", 32'(bus.observer_state), 32'd1);
        rst = 1'b1;
        tick;
        chk("mrst start", 32'(bus.start), 32'd0);
        chk("mrst done", 32'(bus.done), 32'd0);
        chk("mrst official", 32'(bus.official_state), 32'd0);
        chk("mrst observer", 32'(bus.observer_state), 32'd0);
        chk("mrst count", 32'(bus.race_count), 32'd0);
        rst = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/race_handshake.md
# race_handshake

Start/finish handshake block built from three submodules: a race official (`race_official`), a race observer (`race_observer`) and a pseudo-random pulse generator (`random_timer`). The official asserts `start` after an external `ready` request. The observer times a fixed-length race and answers with `done`. Both sides then return to idle through a four-phase handshake. The random timer supplies an irregular pulse `t` that the environment uses to pace `ready` requests.

## Interface
Parameters:
- `RACE_CYCLES`, default 4: number of cycles the observer spends in TIMING; legal range 1..255.
- `LFSR_SEED`, default 16'hACE1: reset value of the timer LFSR; must be nonzero.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `ready` in 1: race request from the environment; sampled only in official IDLE.
- `start` out 1: official's start flag; registered (Moore).
- `done` out 1: observer's finish flag; registered (Moore).
- `t` out 1: random-timer pulse.
- `official_state` out 2: official FSM state code (debug).
- `observer_state` out 2: observer FSM state code (debug).
- `race_count` out 8: number of completed races; wraps 255 -> 0.

## Operation
- Reset values (`rst`=1 at an edge):
  - Both FSMs go to state 0.
  - `start`=0, `done`=0, `race_count`=0.
  - LFSR = `LFSR_SEED`, so `t` = (seed[3:0]==0) = 0.
  - Reset overrides everything, including mid-race.
- Official FSM:
  - States: 0 IDLE, 1 GO, 2 CLEAR; code 3 is illegal and recovers to IDLE.
  - `start` = (state==GO).
  - IDLE: `ready`=1 -> GO.
  - GO: `done`=1 -> CLEAR. `ready` is ignored in GO; once committed, `start` holds.
  - CLEAR: `done`=0 -> IDLE. `ready` is ignored in CLEAR.
- Observer FSM:
  - States: 0 IDLE, 1 TIMING, 2 DONE; code 3 is illegal and recovers to IDLE.
  - `done` = (state==DONE).
  - IDLE: `start`=1 -> TIMING, with cycle counter cleared to 0.
  - TIMING:
    - Counter increments each cycle.
    - When counter==`RACE_CYCLES`-1 -> DONE, and `race_count` increments by 1 (mod 256) on that transition.
    - If `start` drops while TIMING -> abort to IDLE; no count increment.
  - DONE: `start`=0 -> IDLE.
  - Counter width is 8 bits.
- Random timer:
  - 16-bit Fibonacci LFSR with taps 16,14,13,11: new bit = l[15]^l[13]^l[12]^l[10], shifted into bit 0 every cycle.
  - `t` = (lfsr[3:0]==4'b0000), combinational from the register, giving about one pulse per 16 cycles.
  - The LFSR never reaches all-zero.
- Environment protocol (the block does not enforce it):
  - `ready` is raised only when `t`=1, `start`=0 and `done`=0.
  - `ready` is dropped after `start`=1 is seen.

## Timing
Sequence, with `ready` sampled high at edge N while the official is in IDLE:
- N+1: `start`=1 (official in GO).
- N+2: observer enters TIMING.
- N+2+`RACE_CYCLES`: `done`=1.
- N+3+`RACE_CYCLES`: `start`=0 (CLEAR).
- N+4+`RACE_CYCLES`: `done`=0 (observer IDLE).
- N+5+`RACE_CYCLES`: official IDLE; a new `ready` is accepted at this edge or later.

Boundary rules:
- Full cycle time is `RACE_CYCLES`+5 edges, including the turnaround.
- `start` and `done` are both 1 for exactly one cycle per race.
- Simultaneous events resolve by the current-state rules alone: each FSM samples only the other's registered output, so there are no combinational loops.
- `ready` held continuously high gives back-to-back races with no extra idle cycle beyond the sequence above.
- `race_count` 255 plus one completed race -> 0.

## Test plan
- Reset: `rst`=1 for 2 cycles -> `start`=0, `done`=0, both states 0, `race_count`=0, `t`=0.
- Single race (`RACE_CYCLES`=4): `ready` pulsed high at edge 10 ->
  - `start`=1 over edges 11..17.
  - `done`=1 over edges 16..18.
  - official back to IDLE at edge 19.
  - `race_count`=1.
- Paced bench:
  - Drive `ready` per the protocol using `t` for 200 cycles.
  - Check ordering start↑ < done↑ < start↓ < done↓ for every race.
  - Check `race_count` equals the number of done↑ events.
- Ignored request: `ready`=1 while the official is in GO or CLEAR -> no extra race and no state change beyond the normal sequence.
- Mid-race reset: assert `rst` at edge N+3 -> at the next edge `start`=0, `done`=0, both FSMs in IDLE, `race_count`=0.
- LFSR check: after reset, the first 20 `t` values match a reference model seeded with 16'hACE1; no all-zero state appears over 65535 cycles.
